// File: rtl/brs_pkg.sv
// Shared types and constants for the operand-pair sequencer: FSM encoding,
// uio pin assignments and the default buffer depth.
package brs_pkg;

    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // uio bit positions: [3:0] are strobe inputs, [7:4] are status outputs
    localparam int WR_A  = 0;
    localparam int WR_B  = 1;
    localparam int START = 2;
    localparam int CLR   = 3;
    localparam int BUSY  = 4;
    localparam int DONE  = 5;
    localparam int FULL  = 6;
    localparam int OVF   = 7;

    localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/brs_op_sequencer_if.sv
// Tiny Tapeout style pin bundle between the harness (master) and the sequencer (slave).
interface brs_op_sequencer_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input  uo_out, uio_out, uio_oe);
    modport slave  (input  ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/brs_logic_unit.sv
// Conditional logic unit: A[7] selects AND, otherwise XOR, bitwise over 8 bits.
module brs_logic_unit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] c
);
    assign c = a[7] ? (a & b) : (a ^ b);
endmodule

// File: rtl/brs_op_sequencer.sv
// Buffers operand pairs in a small FIFO and, on start, streams them one per cycle
// through the logic unit, folding each result into an XOR accumulator.
module brs_op_sequencer
    import brs_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    brs_op_sequencer_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [3:0]                  ctl_q;
    logic [3:0]                  ctl_edge;
    logic [7:0]                  a_hold;
    logic [7:0]                  acc;
    logic [FIFO_DEPTH-1:0][15:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic [AW:0]                 count;
    state_t                      state;
    logic                        done_q;
    logic                        ovf_q;

    logic       pop;
    logic       push_ok;
    logic       last_pop;
    logic       start_ok;
    logic       busy;
    logic       full;
    logic [7:0] head_a;
    logic [7:0] head_b;
    logic [7:0] c;

    // Strobes act on the first edge that sees them high
    assign ctl_edge = bus.uio_in[3:0] & ~ctl_q;

    assign pop      = (state == ST_RUN);
    assign push_ok  = ctl_edge[WR_B] && ((count != DEPTH_C) || pop);
    assign last_pop = pop && (count == (AW+1)'(1)) && !push_ok;
    assign start_ok = ctl_edge[START] && (state != ST_RUN) && (count != '0);

    assign {head_a, head_b} = mem[rd_ptr];

    brs_logic_unit u_lu (
        .a (head_a),
        .b (head_b),
        .c (c)
    );

    // Storage needs no reset: count gates every read
    always_ff @(posedge clk) begin
        if (push_ok && !ctl_edge[CLR])
            mem[wr_ptr] <= {a_hold, bus.ui_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q  <= '0;
            a_hold <= '0;
            acc    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= ST_IDLE;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            ctl_q <= bus.uio_in[3:0];
            if (ctl_edge[CLR]) begin
                // clr wins over every other strobe on the same edge
                acc    <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                state  <= ST_IDLE;
                done_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                if (ctl_edge[WR_A])
                    a_hold <= bus.ui_in;
                if (push_ok)
                    wr_ptr <= wr_ptr + 1'b1;
                if (ctl_edge[WR_B] && !push_ok)
                    ovf_q <= 1'b1;
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    acc    <= acc ^ c;
                end
                count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
                case (state)
                    ST_RUN: begin
                        if (last_pop) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end
                    end
                    default: begin
                        if (start_ok) begin
                            state  <= ST_RUN;
                            done_q <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign busy = (state == ST_RUN);
    assign full = (count == DEPTH_C);

    assign bus.uo_out  = acc;
    assign bus.uio_out = {ovf_q, full, done_q, busy, 4'b0000};
    assign bus.uio_oe  = UIO_OE_MASK;

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.ena, bus.uio_in[7:4]};

endmodule

// File: tb/tb_brs_op_sequencer.sv
// Directed bench for brs_op_sequencer: reset, XOR/AND paths, batch with full and
// overflow, push during pop, and clr/reset aborting a run.
module tb_brs_op_sequencer;
    import brs_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   n;

    brs_op_sequencer_if bus ();

    brs_op_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input int idx, input logic [7:0] d);
        @(negedge clk);
        bus.ui_in       = d;
        bus.uio_in[idx] = 1'b1;
        @(negedge clk);
        bus.uio_in[idx] = 1'b0;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        strobe(WR_A, a);
        strobe(WR_B, b);
    endtask

    // Called right after a start strobe returns; counts cycles busy stays high
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (bus.uio_out[BUSY] && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst_n      = 1'b1;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;

        // Reset asserted mid-cycle takes effect immediately
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_uo", 32'(bus.uo_out), 32'h00);
        chk("rst_uio", 32'(bus.uio_out), 32'h00);
        chk("rst_oe", 32'(bus.uio_oe), 32'hF0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_uo", 32'(bus.uo_out), 32'h00);
        chk("post_rst_uio", 32'(bus.uio_out), 32'h00);

        // XOR path
        push(8'h35, 8'h0F);
        strobe(START, 8'h00);
        count_busy(n);
        chk("xor_busy_cycles", 32'(n), 32'd1);
        chk("xor_uo", 32'(bus.uo_out), 32'h3A);
        chk("xor_done", 32'(bus.uio_out[DONE]), 32'd1);

        // AND path
        strobe(CLR, 8'h00);
        chk("clr_uo", 32'(bus.uo_out), 32'h00);
        chk("clr_done", 32'(bus.uio_out[DONE]), 32'd0);
        push(8'h9C, 8'hF5);
        strobe(START, 8'h00);
        count_busy(n);
        chk("and_busy_cycles", 32'(n), 32'd1);
        chk("and_uo", 32'(bus.uo_out), 32'h94);
        chk("and_done", 32'(bus.uio_out[DONE]), 32'd1);

        // Batch fill, overflow, drain
        strobe(CLR, 8'h00);
        push(8'h01, 8'h02);
        push(8'h10, 8'h30);
        push(8'h80, 8'hFF);
        push(8'h7F, 8'h01);
        chk("batch_full", 32'(bus.uio_out[FULL]), 32'd1);
        chk("batch_ovf_pre", 32'(bus.uio_out[OVF]), 32'd0);
        push(8'hAA, 8'hBB);
        chk("batch_ovf", 32'(bus.uio_out[OVF]), 32'd1);
        chk("batch_full_hold", 32'(bus.uio_out[FULL]), 32'd1);
        strobe(START, 8'h00);
        count_busy(n);
        chk("batch_busy_cycles", 32'(n), 32'd4);
        chk("batch_uo", 32'(bus.uo_out), 32'hDD);
        chk("batch_full_after", 32'(bus.uio_out[FULL]), 32'd0);
        chk("batch_done", 32'(bus.uio_out[DONE]), 32'd1);
        chk("batch_ovf_sticky", 32'(bus.uio_out[OVF]), 32'd1);

        // Push on the first RUN cycle while full: accepted alongside the pop
        strobe(CLR, 8'h00);
        chk("sim_ovf_clr", 32'(bus.uio_out[OVF]), 32'd0);
        push(8'h01, 8'h02);
        push(8'h10, 8'h30);
        push(8'h80, 8'hFF);
        push(8'h7F, 8'h01);
        strobe(WR_A, 8'h00);
        @(negedge clk);
        bus.uio_in[START] = 1'b1;
        @(negedge clk);
        bus.uio_in[START] = 1'b0;
        bus.ui_in         = 8'h55;
        bus.uio_in[WR_B]  = 1'b1;
        n = 0;
        while (bus.uio_out[BUSY] && n < 20) begin
            n++;
            @(negedge clk);
            bus.uio_in[WR_B] = 1'b0;
        end
        chk("sim_busy_cycles", 32'(n), 32'd5);
        chk("sim_uo", 32'(bus.uo_out), 32'h88);
        chk("sim_ovf", 32'(bus.uio_out[OVF]), 32'd0);
        chk("sim_done", 32'(bus.uio_out[DONE]), 32'd1);

        // clr during the second RUN cycle
        strobe(CLR, 8'h00);
        push(8'h01, 8'h02);
        push(8'h10, 8'h30);
        push(8'h80, 8'hFF);
        strobe(START, 8'h00);
        @(negedge clk);
        chk("clr_run_partial", 32'(bus.uo_out), 32'h03);
        bus.uio_in[CLR] = 1'b1;
        @(negedge clk);
        bus.uio_in[CLR] = 1'b0;
        chk("clr_run_uo", 32'(bus.uo_out), 32'h00);
        chk("clr_run_uio", 32'(bus.uio_out), 32'h00);
        strobe(START, 8'h00);
        chk("clr_run_empty", 32'(bus.uio_out[BUSY]), 32'd0);

        // Async reset during the second RUN cycle
        push(8'h01, 8'h02);
        push(8'h10, 8'h30);
        push(8'h80, 8'hFF);
        strobe(START, 8'h00);
        @(negedge clk);
        chk("rst_run_partial", 32'(bus.uo_out), 32'h03);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_run_uo", 32'(bus.uo_out), 32'h00);
        chk("rst_run_uio", 32'(bus.uio_out), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        strobe(START, 8'h00);
        chk("rst_run_empty", 32'(bus.uio_out[BUSY]), 32'd0);
        chk("rst_run_uo_hold", 32'(bus.uo_out), 32'h00);
        chk("rst_run_oe", 32'(bus.uio_oe), 32'hF0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
